// File: rtl/ahb_sram_slave.sv
// -----------------------------------------------------------------------------
// ahb_sram_slave
//
// AHB-Lite slave that fronts a word-organised register-array SRAM of
// MEM_WORDS x 32 bits. It supports byte, halfword and word transfers
// (little-endian byte lanes) and can insert WAIT_STATES wait cycles into
// every OKAY transfer. Out-of-range, oversized and misaligned transfers get
// the standard two-cycle ERROR response and leave storage untouched.
//
// Parameters
//   MEM_WORDS    number of 32-bit storage words (>= 2)
//   WAIT_STATES  wait cycles inserted per OKAY transfer (0..15)
//
// Ports
//   HCLK       in   1   bus clock, every state update on its rising edge
//   HRESETn    in   1   synchronous active-low reset (storage is not cleared)
//   HSEL       in   1   slave select from the address decoder
//   HADDR      in   32  address-phase byte address
//   HTRANS     in   2   IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
//   HWRITE     in   1   1 = write, 0 = read
//   HSIZE      in   3   000 byte, 001 halfword, 010 word
//   HBURST     in   2   accepted, ignored
//   HPROT      in   4   accepted, ignored
//   HWDATA     in   32  write data, valid in the data phase
//   HREADY     in   1   bus-level ready; high completes the current address phase
//   HREADYOUT  out  1   this slave's ready; low stretches the data phase
//   HRESP      out  1   0 = OKAY, 1 = ERROR
//   HRDATA     out  32  read data in the final read data-phase cycle, else 0
//   dbg_state  out  2   current FSM state (0 IDLE, 1 WAIT, 2 ERR1, 3 ERR2)
//
// Handshake: an address phase is taken on a rising edge where
// HSEL & HREADY & HTRANS[1] are all high and this slave is itself ready
// (HREADYOUT=1). The data phase that follows ends on the first rising edge
// where HREADYOUT=1; write data is committed on exactly that edge and read
// data is only meaningful while HREADYOUT=1 in that cycle. While HREADYOUT=0
// the master holds its next address phase and nothing new is captured.
// -----------------------------------------------------------------------------
module ahb_sram_slave #(
  parameter int MEM_WORDS   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  output logic [1:0]  dbg_state
);

  localparam int          IDX_W       = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [31:0] MEM_WORDS_L = 32'(MEM_WORDS);
  localparam logic [3:0]  WS          = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  // Registered address-phase information for the transfer in its data phase.
  // dp_valid_q is only set for transfers that passed the error checks, so an
  // error transfer can never write storage or drive read data.
  logic             dp_valid_q;
  logic             dp_write_q;
  logic [IDX_W-1:0] dp_idx_q;
  logic [2:0]       dp_size_q;
  logic [1:0]       dp_lo_q;

  logic [31:0] mem [MEM_WORDS];

  // ---------------------------------------------------------------------------
  // Address-phase decode
  // ---------------------------------------------------------------------------
  logic [31:0] addr_word;
  logic        range_err;
  logic        size_err;
  logic        align_err;
  logic        xfer_err;
  logic        accept;
  logic        accept_ok;
  logic        accept_err;

  assign addr_word  = {2'b00, HADDR[31:2]};
  assign range_err  = (addr_word >= MEM_WORDS_L);
  assign size_err   = (HSIZE > 3'b010);
  assign align_err  = ((HSIZE == 3'b001) && HADDR[0]) ||
                      ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00));
  assign xfer_err   = range_err | size_err | align_err;

  // HREADYOUT is folded in so a stretched data phase never lets a pipelined
  // address slip in, even if HREADY is not tied to our own ready.
  assign accept     = HSEL & HREADY & HTRANS[1] & HREADYOUT;
  assign accept_ok  = accept & ~xfer_err;
  assign accept_err = accept &  xfer_err;

  // ---------------------------------------------------------------------------
  // Response outputs depend on the state register only (no path from inputs)
  // ---------------------------------------------------------------------------
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
      end
      ST_WAIT: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b0;
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      ST_ERR2: begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b1;
      end
      default: begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      // IDLE and ERR2 both end a data phase (HREADYOUT=1), so both may take
      // the next address phase.
      ST_IDLE, ST_ERR2: begin
        if (accept_err) begin
          state_d = ST_ERR1;
          cnt_d   = 4'd0;
        end else if (accept_ok && (WS != 4'd0)) begin
          state_d = ST_WAIT;
          cnt_d   = WS;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end
      end
      // One low cycle per count; leaving when the count hits zero makes the
      // following IDLE cycle the final (HREADYOUT=1) data-phase cycle.
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = cnt_q - 4'd1;
        end
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and data-phase registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_idx_q   <= '0;
      dp_size_q  <= 3'd0;
      dp_lo_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // A data phase ends only on an edge with HREADYOUT=1; until then the
      // registered transfer is held.
      if (HREADYOUT) begin
        dp_valid_q <= accept_ok;
        if (accept_ok) begin
          dp_write_q <= HWRITE;
          dp_idx_q   <= HADDR[IDX_W+1:2];
          dp_size_q  <= HSIZE;
          dp_lo_q    <= HADDR[1:0];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [3:0] lane_en;
  logic       mem_we;

  always_comb begin
    lane_en = 4'b1111;
    case (dp_size_q)
      3'b000:  lane_en = 4'b0001 << dp_lo_q;
      3'b001:  lane_en = dp_lo_q[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b1111;
    endcase
  end

  // Gated by HRESETn so a reset edge that lands on the final data-phase
  // cycle still abandons the write.
  assign mem_we = HRESETn & dp_valid_q & dp_write_q & HREADYOUT;

  // No reset here: storage contents survive HRESETn.
  always_ff @(posedge HCLK) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_en[b]) begin
          mem[dp_idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
        end
      end
    end
  end

  // Asynchronous array read: a read whose address phase overlapped the final
  // cycle of a write to the same word sees that write, because the write has
  // already landed on the edge that starts the read's data phase.
  assign HRDATA = (dp_valid_q && !dp_write_q && HREADYOUT) ? mem[dp_idx_q] : 32'h0;

  assign dbg_state = state_q;

  logic unused_inputs;
  assign unused_inputs = ^{HTRANS[0], HBURST, HPROT};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// -----------------------------------------------------------------------------
// tb_ahb_sram_slave
//
// Two instances share the AHB address/data wires: dut_a with zero wait
// states and dut_b with two. Each instance's HREADY is its own HREADYOUT
// (single-slave bus). Transfers are issued in pipelined fashion by
// bus_cycle(): it drives the next address phase together with the write data
// of the transfer currently in its data phase, waits (bounded) for that data
// phase to end, compares it with the front of the expected queues, then
// pushes expectations for the newly issued transfer from a small memory model.
// -----------------------------------------------------------------------------
module tb_ahb_sram_slave;

  logic        clk = 1'b0;
  logic        hresetn;
  logic        hsel_a, hsel_b;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [1:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;

  logic        ro_a, resp_a, ro_b, resp_b;
  logic [31:0] rd_a, rd_b;
  logic [1:0]  st_a, st_b;

  logic        use_b;
  logic        ro, resp;
  logic [31:0] rd;

  int errors = 0;
  int checks = 0;

  // Scoreboard queues, one entry per issued transfer.
  logic [31:0] exp_q[$];
  logic        exp_resp_q[$];
  int          exp_wait_q[$];
  logic [31:0] wdata_q[$];

  logic [31:0] model_a [256];
  logic [31:0] model_b [256];

  // ---------------------------------------------------------------------------
  // Clock / reset / DUTs
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  ahb_sram_slave #(.MEM_WORDS(256), .WAIT_STATES(0)) dut_a (
    .HCLK(clk), .HRESETn(hresetn), .HSEL(hsel_a), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
    .HPROT(hprot), .HWDATA(hwdata), .HREADY(ro_a), .HREADYOUT(ro_a),
    .HRESP(resp_a), .HRDATA(rd_a), .dbg_state(st_a)
  );

  ahb_sram_slave #(.MEM_WORDS(256), .WAIT_STATES(2)) dut_b (
    .HCLK(clk), .HRESETn(hresetn), .HSEL(hsel_b), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
    .HPROT(hprot), .HWDATA(hwdata), .HREADY(ro_b), .HREADYOUT(ro_b),
    .HRESP(resp_b), .HRDATA(rd_b), .dbg_state(st_b)
  );

  assign ro   = use_b ? ro_b   : ro_a;
  assign resp = use_b ? resp_b : resp_a;
  assign rd   = use_b ? rd_b   : rd_a;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [1:0] lo, input logic [2:0] size);
    logic [31:0] mask;
    case (size)
      3'b000:  mask = 32'h0000_00FF << (8 * lo);
      3'b001:  mask = 32'h0000_FFFF << (8 * lo);
      default: mask = 32'hFFFF_FFFF;
    endcase
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  // Entered and left on a falling clock edge.
  task automatic bus_cycle(input logic valid, input logic wr, input logic [31:0] addr,
                           input logic [2:0] size, input logic [31:0] wdata,
                           input logic is_err);
    int          waits;
    logic [31:0] e_rd;
    logic        e_resp;
    int          e_wait;
    logic [7:0]  idx;
    hsel_a = valid & ~use_b;
    hsel_b = valid & use_b;
    htrans = valid ? 2'b10 : 2'b00;
    haddr  = addr;
    hwrite = wr;
    hsize  = size;
    hwdata = (wdata_q.size() > 0) ? wdata_q[0] : 32'h0;
    #1;
    waits = 0;
    if (exp_q.size() > 0) begin
      e_rd   = exp_q.pop_front();
      e_resp = exp_resp_q.pop_front();
      e_wait = exp_wait_q.pop_front();
      void'(wdata_q.pop_front());
      while (ro !== 1'b1 && waits < 40) begin
        check("resp_low_cycle", {31'b0, resp}, {31'b0, e_resp});
        waits++;
        @(negedge clk);
        #1;
      end
      check("wait_cycles", 32'(waits), 32'(e_wait));
      check("resp_final", {31'b0, resp}, {31'b0, e_resp});
      check("rdata", rd, e_rd);
    end else begin
      check("idle_ready", {31'b0, ro}, 32'd1);
      check("idle_resp", {31'b0, resp}, 32'd0);
      check("idle_rdata", rd, 32'h0);
    end
    if (valid) begin
      idx = addr[9:2];
      wdata_q.push_back(wdata);
      if (is_err) begin
        exp_q.push_back(32'h0);
        exp_resp_q.push_back(1'b1);
        exp_wait_q.push_back(1);
      end else begin
        exp_resp_q.push_back(1'b0);
        exp_wait_q.push_back(use_b ? 2 : 0);
        if (wr) begin
          exp_q.push_back(32'h0);
          if (use_b) model_b[idx] = merge(model_b[idx], wdata, addr[1:0], size);
          else       model_a[idx] = merge(model_a[idx], wdata, addr[1:0], size);
        end else begin
          exp_q.push_back(use_b ? model_b[idx] : model_a[idx]);
        end
      end
    end
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    hresetn = 1'b0;
    use_b   = 1'b0;
    hsel_a  = 1'b0;
    hsel_b  = 1'b0;
    haddr   = 32'h0;
    htrans  = 2'b00;
    hwrite  = 1'b0;
    hsize   = 3'b010;
    hburst  = 2'b00;
    hprot   = 4'b0011;
    hwdata  = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_a_ready", {31'b0, ro_a}, 32'd1);
    check("rst_a_resp",  {31'b0, resp_a}, 32'd0);
    check("rst_a_rdata", rd_a, 32'h0);
    check("rst_a_state", {30'b0, st_a}, 32'd0);
    check("rst_b_ready", {31'b0, ro_b}, 32'd1);
    check("rst_b_state", {30'b0, st_b}, 32'd0);
    hresetn = 1'b1;
    @(negedge clk);

    // Zero wait states: write then back-to-back read
    bus_cycle(1, 1, 32'h10, 3'b010, 32'hDEADBEEF, 0);
    bus_cycle(1, 0, 32'h10, 3'b010, 32'h0, 0);

    // Byte write into a word
    bus_cycle(1, 1, 32'h10, 3'b010, 32'h11223344, 0);
    bus_cycle(1, 1, 32'h13, 3'b000, 32'hAA000000, 0);
    bus_cycle(1, 0, 32'h10, 3'b010, 32'h0, 0);

    // Halfword and byte lanes
    bus_cycle(1, 1, 32'h04, 3'b010, 32'h01020304, 0);
    bus_cycle(1, 1, 32'h06, 3'b001, 32'hBEEF0000, 0);
    bus_cycle(1, 1, 32'h05, 3'b000, 32'h00007700, 0);
    bus_cycle(1, 0, 32'h04, 3'b010, 32'h0, 0);

    // Error transfers leave storage alone (0x400 aliases word 0 if truncated)
    bus_cycle(1, 1, 32'h00,  3'b010, 32'hCAFEF00D, 0);
    bus_cycle(1, 1, 32'h02,  3'b010, 32'h11111111, 1);
    bus_cycle(1, 1, 32'h400, 3'b010, 32'hFFFFFFFF, 1);
    bus_cycle(1, 1, 32'h01,  3'b001, 32'h22222222, 1);
    bus_cycle(1, 1, 32'h00,  3'b011, 32'h33333333, 1);
    bus_cycle(1, 0, 32'h02,  3'b010, 32'h0, 1);
    bus_cycle(1, 0, 32'h00,  3'b010, 32'h0, 0);
    bus_cycle(1, 0, 32'h10,  3'b010, 32'h0, 0);

    // Randomised word traffic
    for (int i = 0; i < 6; i++) begin
      logic [31:0] a;
      a = {22'b0, 8'($urandom_range(32, 63)), 2'b00};
      bus_cycle(1, 1, a, 3'b010, $urandom, 0);
      bus_cycle(1, 0, a, 3'b010, 32'h0, 0);
    end
    bus_cycle(0, 0, 32'h0, 3'b010, 32'h0, 0);

    // Two wait states on dut_b
    use_b = 1'b1;
    bus_cycle(1, 1, 32'h04, 3'b010, 32'h0BADC0DE, 0);
    bus_cycle(1, 0, 32'h04, 3'b010, 32'h0, 0);
    bus_cycle(1, 1, 32'h02, 3'b010, 32'h44444444, 1);
    bus_cycle(1, 1, 32'h20, 3'b010, 32'h12345678, 0);
    bus_cycle(0, 0, 32'h0, 3'b010, 32'h0, 0);

    // Reset during a WAIT cycle of a write to 0x20
    hsel_b = 1'b1;
    htrans = 2'b10;
    haddr  = 32'h20;
    hwrite = 1'b1;
    hsize  = 3'b010;
    @(negedge clk);
    #1;
    check("rst_mid_in_wait", {31'b0, ro_b}, 32'd0);
    hsel_b  = 1'b0;
    htrans  = 2'b00;
    hwdata  = 32'h00000055;
    hresetn = 1'b0;
    @(negedge clk);
    #1;
    check("rst_mid_ready", {31'b0, ro_b}, 32'd1);
    check("rst_mid_resp",  {31'b0, resp_b}, 32'd0);
    check("rst_mid_rdata", rd_b, 32'h0);
    check("rst_mid_state", {30'b0, st_b}, 32'd0);
    hresetn = 1'b1;
    @(negedge clk);
    bus_cycle(1, 0, 32'h20, 3'b010, 32'h0, 0);
    bus_cycle(0, 0, 32'h0, 3'b010, 32'h0, 0);

    // Storage in dut_a survived the reset
    use_b = 1'b0;
    bus_cycle(1, 0, 32'h10, 3'b010, 32'h0, 0);
    bus_cycle(0, 0, 32'h0, 3'b010, 32'h0, 0);

    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb_sram_slave.md
AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 256, giving the number of 32-bit storage words.
REQ-002 The block SHALL have parameter WAIT_STATES, default 0, giving the wait cycles inserted per OKAY transfer (0..15).
REQ-003 The block SHALL use one clock; reset SHALL be synchronous and active-low.
REQ-004 Port HCLK  input  1  bus clock; all state updates on rising edge.
REQ-005 Port HRESETn  input  1  synchronous active-low reset.
REQ-006 Port HSEL  input  1  slave select from the decoder.
REQ-007 Port HADDR  input  32  address-phase byte address.
REQ-008 Port HTRANS  input  2  transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-009 Port HWRITE  input  1  1 = write, 0 = read.
REQ-010 Port HSIZE  input  3  000 byte, 001 halfword, 010 word.
REQ-011 Port HBURST  input  2  accepted, no effect on behaviour.
REQ-012 Port HPROT  input  4  accepted, no effect on behaviour.
REQ-013 Port HWDATA  input  32  write data, valid in the data phase.
REQ-014 Port HREADY  input  1  bus-level ready; high means the current address phase completes.
REQ-015 Port HREADYOUT  output  1  this slave's ready; low extends the data phase.
REQ-016 Port HRESP  output  1  0 = OKAY, 1 = ERROR.
REQ-017 Port HRDATA  output  32  read data, valid when HREADYOUT=1 in the final cycle of a read data phase.

Function
REQ-018 A transfer SHALL be accepted on a rising edge where HSEL=1, HREADY=1 and HTRANS[1]=1; HADDR, HWRITE and HSIZE SHALL be registered at that edge.
REQ-019 IDLE or BUSY transfers, or an address phase with HSEL=0, SHALL give a zero-wait OKAY response (HREADYOUT=1, HRESP=0) and SHALL NOT change storage.
REQ-020 A transfer SHALL be an error when the word index is >= MEM_WORDS, HSIZE > 010, a halfword has HADDR[0]=1, or a word has HADDR[1:0]!=00.
REQ-021 The FSM SHALL have states IDLE, WAIT, ERR1 and ERR2.
REQ-022 Transition IDLE -> WAIT SHALL occur on acceptance of a valid transfer when WAIT_STATES>0; IDLE -> ERR1 SHALL occur on acceptance of an error transfer.
REQ-023 In WAIT, a counter loaded with WAIT_STATES SHALL decrement each cycle with HREADYOUT=0 and HRESP=0; the FSM SHALL return to IDLE when the count reaches 0, giving the final cycle with HREADYOUT=1.
REQ-024 With WAIT_STATES=0, a valid transfer SHALL complete in one data-phase cycle with HREADYOUT=1 and HRESP=0.
REQ-025 ERR1 SHALL drive HREADYOUT=0, HRESP=1; ERR2 SHALL drive HREADYOUT=1, HRESP=1, then go to IDLE, or to ERR1/WAIT if a new transfer is accepted in ERR2.
REQ-026 A write SHALL commit HWDATA to storage on the edge that ends its data phase (HREADYOUT=1), updating only the byte lanes selected by HSIZE and HADDR[1:0] (little-endian).
REQ-027 A read SHALL drive the full 32-bit word at the registered index on HRDATA in the final data-phase cycle; outside read data phases HRDATA SHALL be 0.
REQ-028 A read whose address phase coincides with the final data-phase cycle of a write to the same word SHALL return the newly written data.
REQ-029 An error transfer SHALL NOT modify storage and SHALL return HRDATA=0.
REQ-030 A new address phase SHALL be accepted only when HREADY=1; while HREADYOUT=0, a pipelined address SHALL NOT be captured.

Reset
REQ-031 With HRESETn=0 at a rising edge, the FSM SHALL enter IDLE and the wait counter SHALL clear; HREADYOUT SHALL be 1, HRESP 0, HRDATA 0 on the following cycle.
REQ-032 Reset mid-transfer SHALL abandon the transfer without writing storage; storage contents SHALL NOT be cleared by reset.

Verification
REQ-033 WAIT_STATES=0: write word 0xDEADBEEF to 0x10, then read 0x10 back-to-back -> OKAY, zero waits, HRDATA=0xDEADBEEF.
REQ-034 WAIT_STATES=2: read 0x04 -> HREADYOUT low for exactly 2 cycles, then high with HRESP=0.
REQ-035 Byte write 0xAA to 0x13 over word 0x11223344 -> read 0x10 returns 0xAA223344.
REQ-036 Word access to 0x02, and access to index MEM_WORDS -> ERR1 then ERR2 (HRESP=1, HREADYOUT 0 then 1); storage unchanged.
REQ-037 HRESETn low during a WAIT cycle of a write of 0x55 to 0x20 -> next cycle HREADYOUT=1, HRESP=0, and 0x20 keeps its old value.
